// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch entries pair an instruction word with the PC it was read from.
package ifu_pkg;

    localparam int INST_W = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [INST_W-1:0] HALT_INST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head is read
// straight out of registered storage so the consumer sees stable data.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Flush wins over both ends; a push into a full FIFO is only taken
    // when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word read, a small buffer of
// {pc, inst} pairs, redirect/flush support and a halt on the all-zero word.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic         req_valid,
    input  logic         req_ready,
    output logic [31:0]  req_addr,
    input  logic         resp_valid,
    input  logic [31:0]  resp_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_inst,
    output logic [31:0]  out_pc,
    output logic         halted,
    output fetch_state_e state_dbg
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A valid source holds its payload stable until the transfer; ready may
    // change freely. req_valid is withheld during a redirect cycle, so a
    // redirect never coincides with an accepted request.
    assign req_valid = !rst && (state == ST_IDLE) && !halted &&
                       (count < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign req_addr  = fetch_pc;

    assign push            = (state == ST_WAIT) && resp_valid && !redirect_valid;
    assign push_entry.pc   = req_pc;
    assign push_entry.inst = resp_data;
    assign pop             = out_valid && out_ready;

    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign state_dbg = state;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            halted   <= 1'b0;
            // A request still in flight must have its response swallowed.
            case (state)
                ST_WAIT: state <= resp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state <= resp_valid ? ST_IDLE : ST_DROP;
                default: state <= ST_IDLE;
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_valid) begin
                        state <= ST_IDLE;
                        if (resp_data == HALT_INST) begin
                            halted <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a queue-based reference model of the fetch stage plus
// a simple memory responder, directed scenarios and randomized traffic.
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_inst;
    logic [31:0]  out_pc;
    logic         halted;
    fetch_state_e state_dbg;

    ifu_fetch #(
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffer contents, fetch pointer, outstanding request.
    logic [63:0] exp_q [$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_pc;
    bit          m_busy;
    bit          m_discard;
    bit          m_halted;

    // Memory responder and stimulus probabilities.
    bit          mem_busy;
    int          mem_lat;
    logic [31:0] mem_addr;
    logic [31:0] halt_addr;
    bit          const_mode;
    int          lat_min, lat_max, p_req_ready, p_out_ready, p_redirect;
    bit          force_redir;
    logic [31:0] force_pc;

    // Observations of the DUT for the hand-computed checks.
    logic [31:0] hs_q [$];
    logic [31:0] pop_pc_q [$];
    logic [31:0] pop_inst_q [$];
    logic        s_req_valid, s_out_valid, s_halted;
    logic [31:0] s_req_addr;
    fetch_state_e s_state;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr) return 32'h0;
        if (const_mode) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) | 32'h1;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req_valid();
        return !m_busy && !m_halted && (exp_q.size() < DEPTH) && !redirect_valid;
    endfunction

    task automatic check_outputs();
        chk1("req_valid", req_valid, exp_req_valid());
        chk("req_addr", req_addr, m_fetch_pc);
        chk1("out_valid", out_valid, exp_q.size() != 0);
        chk1("halted", halted, m_halted);
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0][63:32]);
            chk("out_inst", out_inst, exp_q[0][31:0]);
        end
    endtask

    // What one rising edge must do, from the fetch-stage rules.
    task automatic model_edge();
        bit hs;
        bit pop_en;
        hs     = exp_req_valid() && req_ready;
        pop_en = (exp_q.size() != 0) && out_ready;
        if (redirect_valid) begin
            exp_q.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            m_halted   = 0;
            if (m_busy) begin
                if (resp_valid) begin
                    m_busy    = 0;
                    m_discard = 0;
                end else begin
                    m_discard = 1;
                end
            end
        end else begin
            if (pop_en) void'(exp_q.pop_front());
            if (m_busy && resp_valid) begin
                if (!m_discard) begin
                    exp_q.push_back({m_req_pc, resp_data});
                    if (resp_data == 32'h0) m_halted = 1;
                end
                m_busy    = 0;
                m_discard = 0;
            end
            if (hs) begin
                m_req_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_busy     = 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_traffic(input int rr, input int orr, input int lmin, input int lmax, input int pred);
        p_req_ready = rr;
        p_out_ready = orr;
        lat_min     = lmin;
        lat_max     = lmax;
        p_redirect  = pred;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_ready      = 1'b0;
        out_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_busy       = 0;
        exp_q.delete();
        m_fetch_pc = 32'h8000_0000;
        m_req_pc   = '0;
        m_busy     = 0;
        m_discard  = 0;
        m_halted   = 0;
        #1;
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk1("rst_halted", halted, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hs_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
    endtask

    task automatic step();
        logic [7:0] r8;
        @(negedge clk);
        resp_valid     = mem_busy && (mem_lat == 1);
        resp_data      = resp_valid ? mem_word(mem_addr) : $urandom();
        req_ready      = ($urandom_range(0, 99) < p_req_ready);
        out_ready      = ($urandom_range(0, 99) < p_out_ready);
        redirect_valid = force_redir || ($urandom_range(0, 99) < p_redirect);
        r8             = 8'($urandom_range(0, 255));
        redirect_pc    = force_redir ? force_pc : {24'h80_0000, r8};
        #1;
        s_req_valid = req_valid;
        s_req_addr  = req_addr;
        s_out_valid = out_valid;
        s_halted    = halted;
        s_state     = state_dbg;
        check_outputs();
        if (req_valid && req_ready) hs_q.push_back(req_addr);
        if (out_valid && out_ready && !redirect_valid) begin
            pop_pc_q.push_back(out_pc);
            pop_inst_q.push_back(out_inst);
        end
        model_edge();
        if (resp_valid) mem_busy = 0;
        else if (mem_busy) mem_lat--;
        if (req_valid && req_ready) begin
            mem_busy = 1;
            mem_addr = req_addr;
            mem_lat  = $urandom_range(lat_min, lat_max);
        end
    endtask

    task automatic redirect_step(input logic [31:0] pc);
        force_redir = 1;
        force_pc    = pc;
        step();
        force_redir = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst         = 1'b1;
        halt_addr   = 32'hFFFF_FFFF;
        const_mode  = 0;
        force_redir = 0;
        force_pc    = '0;
        set_traffic(100, 100, 1, 1, 0);

        // Straight-line fetch with constant instruction words.
        const_mode = 1;
        do_reset();
        repeat (12) step();
        chk("t1_hs_count_ge3", 32'(hs_q.size() >= 3), 32'd1);
        if (hs_q.size() >= 3) begin
            chk("t1_addr0", hs_q[0], 32'h8000_0000);
            chk("t1_addr1", hs_q[1], 32'h8000_0004);
            chk("t1_addr2", hs_q[2], 32'h8000_0008);
        end
        chk("t1_pop_count_ge3", 32'(pop_pc_q.size() >= 3), 32'd1);
        if (pop_pc_q.size() >= 3) begin
            chk("t1_pc0", pop_pc_q[0], 32'h8000_0000);
            chk("t1_pc2", pop_pc_q[2], 32'h8000_0008);
            chk("t1_inst0", pop_inst_q[0], 32'h0000_0013);
        end
        const_mode = 0;

        // Consumer stalled: buffer fills to four, then one pop frees one slot.
        set_traffic(100, 0, 1, 1, 0);
        do_reset();
        repeat (20) step();
        chk("t2_hs_full", hs_q.size(), 32'd4);
        chk1("t2_req_low", s_req_valid, 1'b0);
        chk1("t2_out_valid", s_out_valid, 1'b1);
        p_out_ready = 100;
        step();
        p_out_ready = 0;
        repeat (10) step();
        chk("t2_hs_after_pop", hs_q.size(), 32'd5);

        // Redirect while waiting; the late response must be dropped.
        set_traffic(100, 100, 3, 3, 0);
        do_reset();
        step();
        hs_q.delete();
        redirect_step(32'h8000_0100);
        step();
        chk("t3_state_drop", 32'(s_state), 32'(ST_DROP));
        chk1("t3_out_valid", s_out_valid, 1'b0);
        repeat (15) step();
        chk("t3_hs_nonempty", 32'(hs_q.size() != 0), 32'd1);
        if (hs_q.size() != 0) chk("t3_next_addr", hs_q[0], 32'h8000_0100);
        chk("t3_pop_nonempty", 32'(pop_pc_q.size() != 0), 32'd1);
        if (pop_pc_q.size() != 0) chk("t3_first_pc", pop_pc_q[0], 32'h8000_0100);

        // Redirect in the same cycle as the response.
        set_traffic(100, 100, 2, 2, 0);
        do_reset();
        step();
        step();
        redirect_step(32'h8000_0200);
        step();
        chk1("t4_req_valid", s_req_valid, 1'b1);
        chk("t4_req_addr", s_req_addr, 32'h8000_0200);
        chk("t4_state_idle", 32'(s_state), 32'(ST_IDLE));
        repeat (10) step();
        chk("t4_pop_nonempty", 32'(pop_pc_q.size() != 0), 32'd1);
        if (pop_pc_q.size() != 0) chk("t4_first_pc", pop_pc_q[0], 32'h8000_0200);

        // Halt marker at 8000_0008, drain, then resume via redirect.
        set_traffic(100, 100, 1, 1, 0);
        halt_addr = 32'h8000_0008;
        do_reset();
        repeat (15) step();
        chk("t5_hs_count", hs_q.size(), 32'd3);
        chk1("t5_halted", s_halted, 1'b1);
        chk1("t5_drained", s_out_valid, 1'b0);
        chk("t5_pop_count", pop_pc_q.size(), 32'd3);
        if (pop_pc_q.size() == 3) begin
            chk("t5_halt_pc", pop_pc_q[2], 32'h8000_0008);
            chk("t5_halt_inst", pop_inst_q[2], 32'h0);
        end
        halt_addr = 32'hFFFF_FFFF;
        redirect_step(32'h8000_0000);
        step();
        chk1("t5_unhalted", s_halted, 1'b0);
        chk1("t5_req_valid", s_req_valid, 1'b1);
        chk("t5_req_addr", s_req_addr, 32'h8000_0000);

        // Address wrap at the top of memory.
        set_traffic(100, 0, 1, 1, 0);
        do_reset();
        redirect_step(32'hFFFF_FFFC);
        repeat (6) step();
        chk("t6_hs_ge2", 32'(hs_q.size() >= 2), 32'd1);
        if (hs_q.size() >= 2) begin
            chk("t6_addr_top", hs_q[0], 32'hFFFF_FFFC);
            chk("t6_addr_wrap", hs_q[1], 32'h0000_0000);
        end

        // Asynchronous reset in the middle of a pending request.
        do_reset();
        step();
        step();
        lat_min = 6;
        lat_max = 6;
        step();
        @(posedge clk);
        #2;
        chk("t6_pre_state", 32'(state_dbg), 32'(ST_WAIT));
        chk1("t6_pre_out_valid", out_valid, 1'b1);
        set_traffic(100, 100, 1, 1, 0);
        do_reset();
        step();
        chk1("t6_post_req_valid", s_req_valid, 1'b1);
        chk("t6_post_req_addr", s_req_addr, 32'h8000_0000);

        // Randomized traffic across several stimulus settings.
        for (int seg = 0; seg < 6; seg++) begin
            set_traffic($urandom_range(30, 100), $urandom_range(20, 100), 1,
                        $urandom_range(1, 4), $urandom_range(0, 8));
            halt_addr = (seg % 2 == 1) ? 32'h8000_0040 : 32'hFFFF_FFFF;
            do_reset();
            repeat (400) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the single-cycle core and drives its `inst`/`pc` inputs.
- Issues word reads to instruction memory through a valid/ready request channel with a response channel. At most one request is outstanding at a time.
- Buffers fetched {pc, inst} pairs in a small FIFO and hands them downstream with valid/ready.
- Supports redirect (flush and refetch from a new PC), and halts fetch after enqueuing an all-zero word, which is the simulation finish marker.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; must be a power of two and at least 2.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, output, 1, memory read request valid.
- req_ready, input, 1, memory accepts the request.
- req_addr, output, 32, word address; always equals the internal fetch_pc.
- resp_valid, input, 1, read data valid (one cycle per accepted request).
- resp_data, input, 32, instruction word.
- redirect_valid, input, 1, flush and restart fetch.
- redirect_pc, input, 32, new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, downstream consumes the head.
- out_inst, output, 32, head instruction.
- out_pc, output, 32, head PC.
- halted, output, 1, an all-zero word has been enqueued; fetch is stopped.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC, FIFO count = 0, state = IDLE, halted = 0.
  - Outputs: req_valid = 0, out_valid = 0, out_inst = 0, out_pc = 0.
  - Memory is reset with this block; no pre-reset response may arrive afterwards.
- FSM states: IDLE, WAIT, DROP.
- IDLE:
  - req_valid = !halted && (count < FIFO_DEPTH) && !redirect_valid. This is combinational, so there is never a handshake in a redirect cycle.
  - On req_valid && req_ready: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), state -> WAIT.
  - req_valid stays high and req_addr stays stable until accepted.
- WAIT:
  - req_valid = 0.
  - On resp_valid: push {req_pc, resp_data}, state -> IDLE.
  - If resp_data == 0, halted <= 1 in the same edge.
  - Space is guaranteed because the request was only issued when count < DEPTH.
- DROP:
  - req_valid = 0.
  - On resp_valid: discard the data, state -> IDLE.
- Redirect (highest priority, any state):
  - FIFO count <= 0; same-cycle push and pop are both suppressed.
  - fetch_pc <= redirect_pc, halted <= 0.
  - Next state:
    - IDLE -> IDLE.
    - WAIT with resp_valid this cycle -> IDLE; the response is discarded.
    - WAIT without resp_valid -> DROP.
    - DROP with resp_valid -> IDLE.
    - DROP without resp_valid -> DROP.
- Output side:
  - out_valid = (count != 0); out_inst/out_pc come from the head entry (registered storage).
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty is impossible (out_valid = 0).
- Full FIFO: no new request. A response already in flight is still accepted, because issue required a free slot.
- Latency: request accepted at cycle N with response at N+k gives out_valid at N+k+1. Minimum fetch-to-output latency is 1 cycle after resp_valid.
- Halted:
  - No new requests are issued.
  - Entries already in the FIFO still drain.
  - Cleared only by redirect or reset.
- Ordering: entries leave in fetch order; out_pc is strictly +4 between consecutive entries unless a redirect intervenes.

Decomposition:
- Package ifu_pkg:
  - RESET_PC default and INST_W = 32 constants.
  - Enum for IDLE/WAIT/DROP.
  - fetch_entry_t struct {pc[31:0], inst[31:0]}.
  - HALT_INST = 32'h0 constant.
- Sub-module ifu_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, head.
  - Same async active-high rst.

Test Plan:
1. Reset, req_ready = 1, memory returns 32'h00000013 at 1-cycle latency, out_ready = 1 → req_addr sequence 8000_0000, 8000_0004, 8000_0008; out_pc matches; out_inst = 0000_0013.
2. out_ready = 0, continuous responses → exactly 4 entries accepted; req_valid drops with count = 4. Pop one → exactly one new request issued.
3. redirect_valid with redirect_pc = 8000_0100 while in WAIT, response arriving 2 cycles later → that response is dropped; next req_addr = 8000_0100; FIFO empty; out_valid = 0 until its data returns.
4. Redirect in the same cycle as resp_valid in WAIT → response discarded, state IDLE, next request to the new PC on the following cycle.
5. Memory returns 32'h0 at pc 8000_0008 → entry enqueued, halted = 1, no further req_valid; the FIFO drains. Redirect to 8000_0000 → halted = 0 and fetch resumes.
6. redirect_pc = FFFF_FFFC → requests FFFF_FFFC then 0000_0000. Async rst asserted mid-WAIT → immediate out_valid = 0, req_valid = 0; after release req_addr = 8000_0000.
